// File: rtl/joy_msx_port.sv
// MSX joystick port: two debounced 8-bit joystick inputs, SOCD cleaning,
// fire3 autofire, and the active-low PSG port A view of the player
// chosen by port_sel. Also exports debounced start buttons and a change pulse.
module joy_msx_port #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] AF_DIV          = 24'd1200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] joystick1,
    input  logic [7:0] joystick2,
    input  logic       port_sel,
    input  logic [1:0] autofire_en,
    output logic [5:0] psg_port_a,
    output logic [1:0] start_btn,
    output logic       joy_changed
);

    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [23:0] AF_LAST  = AF_DIV - 24'd1;

    logic [1:0][7:0] joy_in;
    logic [1:0][7:0] stab;
    logic [1:0]      load;
    logic [23:0]     af_div_cnt;
    logic            af_phase;

    assign joy_in = {joystick2, joystick1};

    // Up+down or left+right together cancel out (both treated released).
    function automatic logic [7:0] clean_socd(input logic [7:0] v);
        logic [7:0] c;
        c    = v;
        c[3] = v[3] & ~v[2];
        c[2] = v[2] & ~v[3];
        c[1] = v[1] & ~v[0];
        c[0] = v[0] & ~v[1];
        return c;
    endfunction

    // DCBAUDLR (active-high) -> MSX port A layout {B, A, R, L, D, U}, active-low.
    function automatic logic [5:0] map_psg(input logic [7:0] v, input logic af_on,
                                           input logic phase);
        logic [7:0] c;
        logic       trig_a;
        c      = clean_socd(v);
        trig_a = c[4] | (af_on & c[6] & phase);
        return ~{c[5], trig_a, c[0], c[1], c[2], c[3]};
    endfunction

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [7:0]  sync_p0;
        logic [7:0]  sync_p1;
        logic [7:0]  prev_p2;
        logic [7:0]  stab_r;
        logic [15:0] cnt;
        logic        steady;
        logic        hit;

        // With a one-cycle debounce any differing sample is accepted at once.
        assign steady  = (sync_p1 == prev_p2) || (DEBOUNCE_CYCLES == 16'd1);
        assign hit     = (sync_p1 != stab_r) && steady && (cnt == CNT_LAST);
        assign load[p] = hit;
        assign stab[p] = stab_r;

        // Two-flop synchronizer plus a copy of the previous synchronized value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_p0 <= 8'h00;
                sync_p1 <= 8'h00;
                prev_p2 <= 8'h00;
            end else begin
                sync_p0 <= joy_in[p];
                sync_p1 <= sync_p0;
                prev_p2 <= sync_p1;
            end
        end

        // Debounce: accept a new vector only after it has been steady long enough.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stab_r <= 8'h00;
                cnt    <= 16'd0;
            end else if (sync_p1 == stab_r) begin
                cnt <= 16'd0;
            end else if (hit) begin
                stab_r <= sync_p1;
                cnt    <= 16'd0;
            end else if (sync_p1 == prev_p2) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= 16'd1;
            end
        end
    end

    // Free-running autofire divider; af_phase flips on every wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_div_cnt <= 24'd0;
            af_phase   <= 1'b0;
        end else if (af_div_cnt == AF_LAST) begin
            af_div_cnt <= 24'd0;
            af_phase   <= ~af_phase;
        end else begin
            af_div_cnt <= af_div_cnt + 24'd1;
        end
    end

    // Registered outputs: selected player's port A view, start buttons, change pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psg_port_a  <= 6'h3F;
            start_btn   <= 2'b00;
            joy_changed <= 1'b0;
        end else begin
            psg_port_a  <= port_sel ? map_psg(stab[1], autofire_en[1], af_phase)
                                    : map_psg(stab[0], autofire_en[0], af_phase);
            start_btn   <= {stab[1][7], stab[0][7]};
            joy_changed <= |load;
        end
    end

endmodule

// File: tb/tb_joy_msx_port.sv
// Directed bench for joy_msx_port with DEBOUNCE_CYCLES=4, AF_DIV=8.
module tb_joy_msx_port;

    logic       clk;
    logic       reset;
    logic [7:0] joystick1;
    logic [7:0] joystick2;
    logic       port_sel;
    logic [1:0] autofire_en;
    logic [5:0] psg_port_a;
    logic [1:0] start_btn;
    logic       joy_changed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc    = 0;
    int p0;

    joy_msx_port #(
        .DEBOUNCE_CYCLES(16'd4),
        .AF_DIV         (24'd8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .port_sel   (port_sel),
        .autofire_en(autofire_en),
        .psg_port_a (psg_port_a),
        .start_btn  (start_btn),
        .joy_changed(joy_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which joy_changed is high (value seen just before each edge).
    always @(posedge clk) begin
        if (!reset && joy_changed === 1'b1) pulses <= pulses + 1;
    end

    // Clock edges since last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic       ph;
        logic [5:0] exp_af;
        logic       sel;

        reset       = 1'b1;
        joystick1   = 8'h00;
        joystick2   = 8'h00;
        port_sel    = 1'b0;
        autofire_en = 2'b00;

        // Reset state
        cycles(3);
        chk("rst_psg", 32'(psg_port_a), 32'h3F);
        chk("rst_start", 32'(start_btn), 32'h0);
        chk("rst_changed", 32'(joy_changed), 32'h0);
        reset = 1'b0;

        // Idle inputs
        p0 = pulses;
        cycles(20);
        chk("idle_psg", 32'(psg_port_a), 32'h3F);
        chk("idle_start", 32'(start_btn), 32'h0);
        chk("idle_pulses", 32'(pulses - p0), 32'd0);

        // Up held: visible exactly 7 cycles after the change
        p0 = pulses;
        joystick1 = 8'h08;
        cycles(6);
        chk("up_lat6", 32'(psg_port_a), 32'h3F);
        cycles(1);
        chk("up_lat7", 32'(psg_port_a), 32'h3E);
        cycles(10);
        chk("up_hold", 32'(psg_port_a), 32'h3E);
        chk("up_pulses", 32'(pulses - p0), 32'd1);
        joystick1 = 8'h00;
        cycles(10);
        chk("up_release", 32'(psg_port_a), 32'h3F);

        // 3-cycle glitch never reaches the output
        p0 = pulses;
        joystick1 = 8'h10;
        cycles(3);
        joystick1 = 8'h00;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            chk("glitch_psg", 32'(psg_port_a), 32'h3F);
        end
        chk("glitch_pulses", 32'(pulses - p0), 32'd0);

        // SOCD on player 2, then fire2, then port select
        p0 = pulses;
        port_sel  = 1'b1;
        joystick2 = 8'h0F;
        cycles(10);
        chk("socd_psg", 32'(psg_port_a), 32'h3F);
        chk("socd_pulses", 32'(pulses - p0), 32'd1);
        joystick2 = 8'h20;
        cycles(10);
        chk("p2_trigb", 32'(psg_port_a), 32'h1F);
        port_sel = 1'b0;
        cycles(1);
        chk("sel_p1", 32'(psg_port_a), 32'h3F);
        port_sel = 1'b1;
        cycles(1);
        chk("sel_p2", 32'(psg_port_a), 32'h1F);

        // port_sel toggling every cycle
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel      = ~sel;
            port_sel = sel;
            cycles(1);
            chk("sel_toggle", 32'(psg_port_a), sel ? 32'h1F : 32'h3F);
        end
        port_sel  = 1'b0;
        joystick2 = 8'h00;
        cycles(10);

        // Autofire on player 1 fire3, locked to af_phase
        autofire_en = 2'b01;
        joystick1   = 8'h40;
        cycles(10);
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            ph     = 1'(((cyc - 1) / 8) % 2);
            exp_af = {1'b1, ~ph, 4'hF};
            chk("autofire", 32'(psg_port_a), 32'(exp_af));
        end
        autofire_en = 2'b00;
        cycles(2);
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            chk("af_off", 32'(psg_port_a), 32'h3F);
        end
        joystick1 = 8'h00;
        cycles(10);

        // Reset in the middle of debouncing start, input held through release
        joystick1 = 8'h80;
        cycles(4);
        chk("mid_start", 32'(start_btn), 32'h0);
        reset = 1'b1;
        cycles(2);
        chk("mid_rst_start", 32'(start_btn), 32'h0);
        chk("mid_rst_psg", 32'(psg_port_a), 32'h3F);
        reset = 1'b0;
        cycles(6);
        chk("rel_start6", 32'(start_btn), 32'h0);
        cycles(1);
        chk("rel_start7", 32'(start_btn), 32'h1);
        chk("rel_psg", 32'(psg_port_a), 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_msx_port.md
JOY_MSX_PORT -- requirements
Module: joy_msx_port

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive stable cycles required before a joystick vector is accepted; legal range 1..65535.
REQ-002 SHALL provide parameter AF_DIV, default 24'd1200000: clk cycles per autofire half-period; legal range 1..2^24-1.
REQ-003 clk  input  1  system clock, 48-50 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 joystick1  input  8  player-1 buttons, active-high, bit order DCBAUDLR: 0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2, 6 fire3, 7 start; asynchronous to clk.
REQ-006 joystick2  input  8  player-2 buttons, same encoding and timing as joystick1.
REQ-007 port_sel  input  1  MSX PSG register 15 bit 6; 0 selects player 1, 1 selects player 2.
REQ-008 autofire_en  input  2  bit n enables autofire on fire3 for player n+1.
REQ-009 psg_port_a  output  6  MSX joystick read value, active-low: 0 up, 1 down, 2 left, 3 right, 4 trigger A, 5 trigger B.
REQ-010 start_btn  output  2  debounced start, active-high; bit n = player n+1.
REQ-011 joy_changed  output  1  single-cycle pulse when either debounced vector changes.

Function
REQ-012 Each joystick input SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-013 Each player SHALL keep a debounced vector stab[7:0] and a 16-bit counter cnt.
REQ-014 When sync == stab, cnt SHALL be cleared to 0.
REQ-015 When sync != stab and sync equals its value of the previous cycle, cnt SHALL increment; a differing previous value SHALL reset cnt to 1.
REQ-016 When cnt reaches DEBOUNCE_CYCLES-1 with sync != stab, stab SHALL load sync on that clock edge and cnt SHALL clear; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach stab.
REQ-017 joy_changed SHALL assert for exactly one cycle, the cycle after either stab is updated; simultaneous updates of both players SHALL produce one pulse.
REQ-018 SOCD cleaning on stab: up and down both set -> both treated released; left and right both set -> both treated released.
REQ-019 An autofire divider SHALL count 0..AF_DIV-1 and toggle af_phase on wrap; af_phase resets to 0 and runs continuously regardless of autofire_en.
REQ-020 Trigger A (pressed) = fire1 OR (autofire_en[n] AND fire3 AND af_phase); trigger B (pressed) = fire2; start is not mapped to psg_port_a.
REQ-021 psg_port_a SHALL be registered: the cleaned, mapped, inverted vector of the player chosen by port_sel, updated every cycle; latency 1 cycle from port_sel or stab change.
REQ-022 Total latency, input change to psg_port_a: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-023 start_btn SHALL be registered from stab bit 7 of each player, same latency as psg_port_a.
REQ-024 port_sel toggling every cycle SHALL be honoured every cycle with no extra state.

Reset
REQ-025 Asserting reset SHALL immediately set: synchronizers and stab to 8'h00, cnt 0, divider 0, af_phase 0, psg_port_a 6'h3F, start_btn 2'b00, joy_changed 0.
REQ-026 Reset asserted mid-debounce SHALL discard the pending change; after release the held input is re-debounced from cnt 0.
REQ-027 First clock after reset release SHALL perform normal operation; no outputs other than those of REQ-025 change during reset.

Verification (DEBOUNCE_CYCLES=4, AF_DIV=8 unless stated)
REQ-028 Reset, idle inputs -> psg_port_a=6'h3F, start_btn=0, joy_changed never pulses.
REQ-029 joystick1=8'h08 (up) held, port_sel=0 -> psg_port_a=6'h3E exactly 7 cycles after change; single joy_changed pulse.
REQ-030 joystick1 pulse of 8'h10 for 3 cycles -> psg_port_a stays 6'h3F, no joy_changed.
REQ-031 joystick2=8'h0F (all directions), port_sel=1 -> psg_port_a=6'h3F (SOCD); then joystick2=8'h20 -> 6'h1F; port_sel=0 -> 6'h3F next cycle.
REQ-032 autofire_en=2'b01, joystick1=8'h40 held -> psg_port_a bit 4 alternates 8 cycles low / 8 high, locked to af_phase; autofire_en=0 -> bit 4 stays 1.
REQ-033 Reset asserted on cycle 2 of a 4-cycle debounce of joystick1=8'h80, released with input held -> start_btn[0]=1 only after full 2+4+1 cycles from release.
